bcd_updown_counter: RTL
=======================

# bcd_updown_counter

Parametrised synchronous BCD up/down counter: the next generation of the team's 5-digit decimal event counter. It adds a configurable digit count, count direction, count enable, parallel load with BCD validation, synchronous clear, selectable wrap or saturate at the range limits, and terminal-count/carry status. It sits between event/strobe logic and the seven-segment display drivers. It also serves as a cascadable decade counter for timers and scoreboards.

## Interface

Parameters:
- DIGITS, default 5 — number of BCD digits, 1..8; counter width W = 4*DIGITS.
- WRAP, default 1 — 1: wrap at range limits; 0: saturate at range limits.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear to zero.
- load  in  1  synchronous parallel load request.
- load_value  in  W  BCD value to load; digit i is [4i+3:4i]; digit 0 is least significant.
- en  in  1  count enable; one step per cycle while high.
- up  in  1  direction: 1 = increment, 0 = decrement.
- value  out  W  registered BCD count.
- tc  out  1  combinational terminal count; value equals the range limit in the current direction.
- carry  out  1  registered one-cycle pulse on a range-limit event (carry when counting up, borrow when counting down).
- load_err  out  1  registered one-cycle pulse when a load is rejected.

## Operation

- Reset (reset_n low, asynchronous): value = 0, carry = 0, load_err = 0. These hold while reset_n is low.
- Per-cycle priority: clear > load > en. Only one action is taken per cycle.
- clear: value ← 0. carry and load_err are 0 that cycle.
- load with a valid load_value (every digit ≤ 9): value ← load_value. The en input is ignored that cycle.
- load with any digit > 9: value is unchanged, load_err ← 1 for one cycle, and no count occurs that cycle.
- Count up (en=1, up=1):
  - Digit i increments if all lower digits equal 9.
  - A digit at 9 that increments rolls to 0.
  - Digit 0 always steps.
- Count down (en=1, up=0):
  - Digit i decrements if all lower digits equal 0.
  - A digit at 0 that decrements rolls to 9.
- Range limits: the top is all 9s (10^DIGITS − 1) and the bottom is 0.
  - Up at the top: WRAP=1 gives value ← 0; WRAP=0 holds the value. carry ← 1 in both cases.
  - Down at the bottom: WRAP=1 gives value ← all 9s; WRAP=0 holds the value. carry ← 1 in both cases.
- Saturate mode: carry pulses on every enabled cycle spent at the limit in the limit direction.
- en=0 with no clear or load: value holds; carry = 0 and load_err = 0.
- tc = (up ? value == all 9s : value == 0). tc is not qualified by en, so it supports cascading: the next stage's en = this en & tc.
- Outputs never hold a non-BCD digit. Arithmetic is per-digit 4-bit; there are no binary adders across digit boundaries.

## Timing

- value, carry and load_err update on the rising clk edge after the inputs are sampled: one-cycle latency.
- carry and load_err are high for exactly the cycle in which value shows the result of that edge.
- tc follows value and up combinationally within the same cycle.
- A direction change takes effect on the next edge. There is no pipeline or turnaround penalty.
- Reset deassertion is synchronised by the system. The first count occurs on the first rising edge with reset_n high and en=1.
- Reset asserted mid-count clears all outputs immediately, without waiting for clk.

## Test plan

- DIGITS=5, WRAP=1: reset, then en=1, up=1 for 100000 cycles.
  - value steps 00000 → 99999 → 00000.
  - carry pulses exactly once, on the cycle value becomes 00000.
  - tc is high only at 99999.
- Digit rollover: load 00099 then up 1 cycle → 00100; load 09999 then up 1 cycle → 10000; load 10000 then down 1 cycle → 09999.
- Down wrap/saturate:
  - WRAP=1: value 00000, down 1 cycle → 99999, carry=1, tc was 1 before the edge.
  - WRAP=0: value 00000, down 3 cycles → stays 00000, with carry high on all 3 cycles.
  - WRAP=0: value 99999, up → holds 99999 with carry=1.
- Priority and validation:
  - clear+load+en in one cycle → 00000.
  - load 12345 with en=1 → 12345 (no increment).
  - load_value 1A345 → value unchanged, load_err high 1 cycle.
- Async reset: value 54321 counting, drop reset_n between clock edges → value=0, carry=0 and load_err=0 immediately. Release, en=1, up=1 → 00001 after the first edge.
- DIGITS=1: count up from 8 → 9 (tc=1) → 0 (carry=1). Cascade two instances via en & tc and verify combined 00..99 sequencing.

Source files
------------

// File: rtl/bcd_updown_counter.sv
// BCD up/down counter with parallel load, synchronous clear and wrap or saturate at the
// range limits. Each digit is stepped by its own 4-bit logic and enabled by a ripple chain
// of "all lower digits are 9" (up) or "all lower digits are 0" (down), so no binary adder
// ever spans a digit boundary and the count can never hold a non-BCD digit.
module bcd_updown_counter #(
    parameter int unsigned DIGITS = 5,
    parameter bit          WRAP   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    input  logic                  en,
    input  logic                  up,
    output logic [4*DIGITS-1:0]   value,
    output logic                  tc,
    output logic                  carry,
    output logic                  load_err
);

    localparam int unsigned W = 4 * DIGITS;

    logic [W-1:0]      value_q, value_d;
    logic              carry_q, carry_d;
    logic              load_err_q, load_err_d;

    // Per-digit status and candidate next values for both directions.
    logic [DIGITS-1:0] dig_nine;
    logic [DIGITS-1:0] dig_zero;
    logic [DIGITS-1:0] dig_bad;
    logic [DIGITS:0]   chain_up;
    logic [DIGITS:0]   chain_dn;
    logic [W-1:0]      cnt_up;
    logic [W-1:0]      cnt_dn;

    logic              at_top;
    logic              at_bot;
    logic              load_ok;

    // Digit 0 always steps; higher digits step only when every lower digit is at its limit.
    assign chain_up[0] = 1'b1;
    assign chain_dn[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        logic [3:0] d_cur;
        logic [3:0] d_inc;
        logic [3:0] d_dec;
        logic [3:0] d_ld;

        assign d_cur = value_q[4*g +: 4];
        assign d_ld  = load_value[4*g +: 4];

        assign dig_nine[g] = (d_cur == 4'd9);
        assign dig_zero[g] = (d_cur == 4'd0);
        assign dig_bad[g]  = (d_ld > 4'd9);

        assign chain_up[g+1] = chain_up[g] & dig_nine[g];
        assign chain_dn[g+1] = chain_dn[g] & dig_zero[g];

        // Decade step: 9 rolls to 0 going up, 0 rolls to 9 going down.
        assign d_inc = dig_nine[g] ? 4'd0 : (d_cur + 4'd1);
        assign d_dec = dig_zero[g] ? 4'd9 : (d_cur - 4'd1);

        assign cnt_up[4*g +: 4] = chain_up[g] ? d_inc : d_cur;
        assign cnt_dn[4*g +: 4] = chain_dn[g] ? d_dec : d_cur;
    end

    // The chain carry out of the top digit is exactly "every digit at its limit".
    assign at_top  = chain_up[DIGITS];
    assign at_bot  = chain_dn[DIGITS];
    assign load_ok = ~|dig_bad;

    // Terminal count is deliberately not gated by en so stages can cascade as en & tc.
    assign tc = up ? at_top : at_bot;

    // Next-state selection with priority clear > load > count.
    always_comb begin
        value_d    = value_q;
        carry_d    = 1'b0;
        load_err_d = 1'b0;
        if (clear) begin
            value_d = '0;
        end else if (load) begin
            if (load_ok) begin
                value_d = load_value;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (en) begin
            if (up) begin
                carry_d = at_top;
                // Per-digit rollover already yields 0 at the top; saturation just holds.
                if (!at_top || WRAP) begin
                    value_d = cnt_up;
                end
            end else begin
                carry_d = at_bot;
                // Per-digit rollover already yields all 9s at the bottom.
                if (!at_bot || WRAP) begin
                    value_d = cnt_dn;
                end
            end
        end
    end

    // State and registered status pulses, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_q    <= '0;
            carry_q    <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            value_q    <= value_d;
            carry_q    <= carry_d;
            load_err_q <= load_err_d;
        end
    end

    assign value    = value_q;
    assign carry    = carry_q;
    assign load_err = load_err_q;

endmodule
